otfs_frame_scheduler: RTL and testbench
=======================================

// Module: otfs_frame_scheduler
// PURPOSE
//  Sequences the OTFS 4QAM loopback chain (QAM mod -> OTFS Tx -> OTFS Rx -> QAM demod).
//  Accepts a burst request (frame count + modulation order) and issues one Start pulse per frame.
//  Counts demodulated symbols to detect frame completion and inserts an inter-frame gap.
//  Signals Done on burst completion; a per-frame watchdog reports a stalled chain.
// PARAMETERS
//  N_SYMBOLS       64    demod symbols per frame (QAMDemodDataValid beats)
//  TIMEOUT_CYCLES  4096  max cycles from Start to last symbol of a frame
//  GAP_CYCLES      16    idle cycles between frame completion and next Start (>=1)
// PORTS
//  Clk              in   1  system clock, all logic on rising edge
//  SRst             in   1  synchronous reset, active-high
//  ReqValid         in   1  burst request valid
//  ReqReady         out  1  scheduler can accept a request (IDLE only)
//  ReqFrames        in   8  frames in burst; 0 = empty burst
//  ReqModOrder      in   3  modulation order code for the burst
//  Abort            in   1  terminate current burst
//  Start            out  1  one-cycle start pulse to the chain
//  ModulationOrder  out  3  order code driven to the chain
//  DemodValid       in   1  QAMDemodDataValid from chain
//  Busy             out  1  high in any state except IDLE
//  FramesDone       out  8  frames completed in current/last burst
//  Done             out  1  one-cycle pulse: burst completed normally
//  TimeoutErr       out  1  sticky: watchdog expired; cleared on next accepted request
// BEHAVIOUR
//  Reset: state=IDLE; ReqReady=1; Start=0; ModulationOrder=3'b000; Busy=0; FramesDone=0;
//   Done=0; TimeoutErr=0; internal symbol, watchdog and gap counters = 0. SRst overrides all inputs.
//  All outputs are registered. ReqReady = (state==IDLE).
//  IDLE: on ReqValid&&ReqReady, latch ReqFrames and ReqModOrder.
//   Next cycle ModulationOrder updates; FramesDone<=0; TimeoutErr<=0.
//   ReqFrames==0 -> DONE (no Start); otherwise -> LAUNCH.
//  LAUNCH (1 cycle): Start=1; SymCnt<=0; Wdog<=0; -> WAIT_RX.
//   Start is asserted exactly one cycle per frame.
//   Start rises 2 cycles after the accepting edge.
//  WAIT_RX:
//   - Each DemodValid: SymCnt++.
//   - On the DemodValid with SymCnt==N_SYMBOLS-1: FramesDone++.
//     If FramesDone+1==target -> DONE, else -> GAP.
//   - Wdog++ every cycle. When Wdog reaches TIMEOUT_CYCLES-1 without frame completion:
//     TimeoutErr<=1, -> IDLE, no Done.
//     Completion on the same cycle as expiry counts as completion (completion wins).
//  GAP: count GAP_CYCLES cycles, then -> LAUNCH.
//  DONE (1 cycle): Done=1 -> IDLE. FramesDone holds its value until the next accept.
//  DemodValid outside WAIT_RX is ignored (no counter change, no error).
//  Abort (any non-IDLE state) -> IDLE next cycle; no Done, TimeoutErr unchanged.
//   Abort in LAUNCH suppresses Start that cycle. Abort in IDLE is ignored.
//   Abort and completion on the same cycle: Abort wins, FramesDone not incremented.
//  ModulationOrder stays stable from one accepted request to the next, including across Abort.
//  Widths: SymCnt clog2(N_SYMBOLS+1); Wdog clog2(TIMEOUT_CYCLES+1); counters never wrap.
//   FramesDone max 255, equal to ReqFrames.
// TESTING
//  1 Reset: SRst for 10 cycles -> all outputs at reset values; ReqReady=1; no Start.
//  2 Req(frames=3, mod=3'b000); model returns 64 DemodValid beats ~100 cycles after each Start ->
//    exactly 3 Start pulses, each >=16 cycles after the prior frame's last beat;
//    FramesDone=3; one Done; TimeoutErr=0.
//  3 Req(frames=0) -> Done 2 cycles after accept; no Start; FramesDone=0.
//  4 Req(frames=2); model gives only 63 beats for frame 1 ->
//    TimeoutErr=1 at Start+4096; state IDLE; no Done; next accept clears TimeoutErr.
//  5 Req(frames=4); Abort after frame 2 completes (in GAP) -> no 3rd Start; FramesDone=2;
//    no Done; ReqReady=1 next cycle.
//    Repeat with Abort on the cycle of a final beat -> FramesDone not incremented.
//  6 Req accepted with mod=3'b010; stray DemodValid in IDLE/GAP ->
//    ModulationOrder=3'b010 held; SymCnt unaffected; frame completes on exactly 64 beats.

Source files
------------

// File: rtl/otfs_frame_scheduler_if.sv
// otfs_frame_scheduler_if: burst request, chain control and status bundle for the OTFS frame scheduler
interface otfs_frame_scheduler_if;
  logic ReqValid;
  logic ReqReady;
  logic [7:0] ReqFrames;
  logic [2:0] ReqModOrder;
  logic Abort;
  logic Start;
  logic [2:0] ModulationOrder;
  logic DemodValid;
  logic Busy;
  logic [7:0] FramesDone;
  logic Done;
  logic TimeoutErr;
  modport master (
    output ReqValid, ReqFrames, ReqModOrder, Abort, DemodValid,
    input ReqReady, Start, ModulationOrder, Busy, FramesDone, Done, TimeoutErr
  );
  modport slave (
    input ReqValid, ReqFrames, ReqModOrder, Abort, DemodValid,
    output ReqReady, Start, ModulationOrder, Busy, FramesDone, Done, TimeoutErr
  );
endinterface

// File: rtl/otfs_frame_scheduler.sv
// otfs_frame_scheduler: issues one Start per frame of a burst, counts demod beats, gaps frames, flags Done or watchdog timeout
module otfs_frame_scheduler #(
  parameter int N_SYMBOLS      = 64,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 16
) (
  input logic Clk,
  input logic SRst,
  otfs_frame_scheduler_if.slave bus
);
  localparam int SW = $clog2(N_SYMBOLS + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_RX, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] sym_q, sym_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0] target_q, target_d, frames_q, frames_d;
  logic [2:0] mod_q, mod_d;
  logic timeout_q, timeout_d, start_q, start_d, done_q, done_d, ready_q, ready_d, busy_q, busy_d;
  logic complete;
  always_comb begin
    state_d   = state_q;
    sym_d     = sym_q;
    wdog_d    = wdog_q;
    gap_d     = gap_q;
    target_d  = target_q;
    frames_d  = frames_q;
    mod_d     = mod_q;
    timeout_d = timeout_q;
    complete  = state_q == WAIT_RX && bus.DemodValid && sym_q == SW'(N_SYMBOLS - 1);
    if (bus.Abort && state_q != IDLE) state_d = IDLE;
    else case (state_q)
      IDLE: if (bus.ReqValid) begin
        target_d  = bus.ReqFrames;
        mod_d     = bus.ReqModOrder;
        frames_d  = '0;
        timeout_d = 1'b0;
        state_d   = bus.ReqFrames == 8'd0 ? DONE : LAUNCH;
      end
      LAUNCH: begin
        sym_d   = '0;
        wdog_d  = '0;
        state_d = WAIT_RX;
      end
      WAIT_RX: begin
        sym_d  = bus.DemodValid ? sym_q + SW'(1) : sym_q;
        wdog_d = wdog_q + WW'(1);
        if (complete) begin
          frames_d = frames_q + 8'd1;
          gap_d    = '0;
          state_d  = frames_q + 8'd1 == target_q ? DONE : GAP;
        end else if (wdog_q == WW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      GAP: begin
        gap_d   = gap_q + GW'(1);
        state_d = gap_q == GW'(GAP_CYCLES - 1) ? LAUNCH : GAP;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    start_d = state_q == LAUNCH && !bus.Abort;
    done_d  = state_q == DONE && !bus.Abort;
    ready_d = state_d == IDLE;
    busy_d  = state_d != IDLE;
  end
  always_ff @(posedge Clk) begin
    if (SRst) begin
      state_q   <= IDLE;
      sym_q     <= '0;
      wdog_q    <= '0;
      gap_q     <= '0;
      target_q  <= '0;
      frames_q  <= '0;
      mod_q     <= '0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_q     <= sym_d;
      wdog_q    <= wdog_d;
      gap_q     <= gap_d;
      target_q  <= target_d;
      frames_q  <= frames_d;
      mod_q     <= mod_d;
      timeout_q <= timeout_d;
      start_q   <= start_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end
  assign bus.ReqReady        = ready_q;
  assign bus.Start           = start_q;
  assign bus.ModulationOrder = mod_q;
  assign bus.Busy            = busy_q;
  assign bus.FramesDone      = frames_q;
  assign bus.Done            = done_q;
  assign bus.TimeoutErr      = timeout_q;
endmodule

// File: tb/tb_otfs_frame_scheduler.sv
// tb_otfs_frame_scheduler: scoreboard bench with a loopback chain model driving demod beats after each Start
module tb_otfs_frame_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic abort_stim = 1'b0, abort_model = 1'b0, model_beat = 1'b0, stray = 1'b0, abort_last = 1'b0;
  int total = 0, bad = 0;
  int cyc = 0, acc_cyc = 0, ref_cyc = 0, st_cyc = 0;
  logic to_prev = 1'b0;
  typedef struct {int k; int fd; int mo; int dt;} exp_t;
  exp_t exp_q[$];
  int beats_q[$];
  otfs_frame_scheduler_if bus ();
  otfs_frame_scheduler dut (.Clk(clk), .SRst(rst), .bus(bus));
  assign bus.Abort      = abort_stim | abort_model;
  assign bus.DemodValid = model_beat | stray;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, req, $time);
    end
  endtask
  task automatic expect_ev(input int k, input int fd, input int mo, input int dt);
    exp_q.push_back('{k, fd, mo, dt});
  endtask
  task automatic ev(input int k, input string nm, input int dt);
    exp_t e;
    int fd = int'(bus.FramesDone);
    int mo = int'(bus.ModulationOrder);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_%s got fd=%0d mod=%0d want no event t=%0t", nm, fd, mo, $time);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, "_kind"}, k, e.k);
    chk({nm, "_frames"}, fd, e.fd);
    chk({nm, "_mod"}, mo, e.mo);
    chk({nm, "_dt"}, dt, e.dt);
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ReqValid && bus.ReqReady) acc_cyc = cyc;
      if (model_beat) ref_cyc = cyc;
      if (bus.Start) begin
        ev(0, "start", cyc - (ref_cyc > acc_cyc ? ref_cyc : acc_cyc));
        st_cyc = cyc;
      end
      if (bus.Done) ev(1, "done", cyc - (ref_cyc > acc_cyc ? ref_cyc : acc_cyc));
      if (bus.TimeoutErr && !to_prev) ev(2, "timeout", cyc - st_cyc);
      to_prev = bus.TimeoutErr;
    end
  end
  initial begin
    int n;
    logic al;
    forever begin
      @(negedge clk);
      if (bus.Start) begin
        n  = beats_q.size() != 0 ? beats_q.pop_front() : 64;
        al = abort_last;
        repeat (100) @(posedge clk);
        for (int i = 0; i < n; i++) begin
          @(posedge clk);
          #1;
          model_beat  = 1'b1;
          abort_model = al && i == n - 1;
        end
        @(posedge clk);
        #1;
        model_beat  = 1'b0;
        abort_model = 1'b0;
      end
    end
  end
  task automatic req(input int f, input int m);
    @(posedge clk);
    #1;
    bus.ReqValid    = 1'b1;
    bus.ReqFrames   = 8'(f);
    bus.ReqModOrder = 3'(m);
    @(posedge clk);
    #1;
    bus.ReqValid = 1'b0;
  endtask
  task automatic wait_idle(input int limit);
    int ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!bus.Busy) begin
        ok = 1;
        break;
      end
    end
    chk("wait_idle_bound", ok, 1);
  endtask
  task automatic wait_fd(input int n, input int limit);
    int ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (int'(bus.FramesDone) == n) begin
        ok = 1;
        break;
      end
    end
    chk("wait_frames_bound", ok, 1);
  endtask
  initial begin
    bus.ReqValid    = 1'b1;
    bus.ReqFrames   = 8'd3;
    bus.ReqModOrder = 3'd7;
    abort_stim      = 1'b1;
    stray           = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(bus.ReqReady), 1);
    chk("rst_start", int'(bus.Start), 0);
    chk("rst_mod", int'(bus.ModulationOrder), 0);
    chk("rst_busy", int'(bus.Busy), 0);
    chk("rst_frames", int'(bus.FramesDone), 0);
    chk("rst_done", int'(bus.Done), 0);
    chk("rst_timeout", int'(bus.TimeoutErr), 0);
    bus.ReqValid = 1'b0;
    abort_stim   = 1'b0;
    stray        = 1'b0;
    rst          = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_ready", int'(bus.ReqReady), 1);
    expect_ev(0, 0, 0, 2);
    expect_ev(0, 1, 0, 18);
    expect_ev(0, 2, 0, 18);
    expect_ev(1, 3, 0, 2);
    req(3, 0);
    wait_idle(2000);
    chk("burst3_frames", int'(bus.FramesDone), 3);
    chk("burst3_timeout", int'(bus.TimeoutErr), 0);
    expect_ev(1, 0, 5, 2);
    req(0, 5);
    wait_idle(50);
    chk("empty_frames", int'(bus.FramesDone), 0);
    chk("empty_mod", int'(bus.ModulationOrder), 5);
    beats_q.push_back(63);
    expect_ev(0, 0, 6, 2);
    expect_ev(2, 0, 6, 4096);
    req(2, 6);
    wait_idle(6000);
    chk("wdog_timeout", int'(bus.TimeoutErr), 1);
    chk("wdog_ready", int'(bus.ReqReady), 1);
    chk("wdog_frames", int'(bus.FramesDone), 0);
    expect_ev(0, 0, 1, 2);
    expect_ev(0, 1, 1, 18);
    req(4, 1);
    chk("accept_clears_timeout", int'(bus.TimeoutErr), 0);
    wait_fd(2, 1000);
    @(posedge clk);
    #1;
    abort_stim = 1'b1;
    @(posedge clk);
    #1;
    abort_stim = 1'b0;
    chk("gap_abort_ready", int'(bus.ReqReady), 1);
    chk("gap_abort_busy", int'(bus.Busy), 0);
    chk("gap_abort_frames", int'(bus.FramesDone), 2);
    chk("gap_abort_mod", int'(bus.ModulationOrder), 1);
    repeat (200) @(posedge clk);
    abort_last = 1'b1;
    expect_ev(0, 0, 3, 2);
    req(2, 3);
    wait_idle(1000);
    abort_last = 1'b0;
    chk("last_beat_abort_frames", int'(bus.FramesDone), 0);
    chk("last_beat_abort_ready", int'(bus.ReqReady), 1);
    chk("last_beat_abort_timeout", int'(bus.TimeoutErr), 0);
    repeat (200) @(posedge clk);
    #1;
    stray = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stray = 1'b0;
    chk("idle_stray_busy", int'(bus.Busy), 0);
    chk("idle_stray_frames", int'(bus.FramesDone), 0);
    expect_ev(0, 0, 2, 2);
    expect_ev(0, 1, 2, 18);
    expect_ev(1, 2, 2, 2);
    req(2, 2);
    wait_fd(1, 1000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      stray = 1'b1;
      @(posedge clk);
      #1;
      stray = 1'b0;
    end
    wait_idle(1000);
    chk("stray_mod_held", int'(bus.ModulationOrder), 2);
    chk("stray_frames", int'(bus.FramesDone), 2);
    repeat (20) @(posedge clk);
    chk("scoreboard_pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL global_time_limit got=running want=finished");
    $fatal(1, "time limit");
  end
endmodule
